// File: rtl/ahb2_sram_slv.sv
// ahb2_sram_slv: AHB2 slave terminating one decoded slave port on a word-wide on-chip SRAM.
// Byte/half/word transfers, WAIT_CNT programmable wait states per OKAY data phase, two-cycle
// ERROR response on illegal transfers. Never issues RETRY or SPLIT.
//
// Parameters
//   MEM_DEPTH  number of 32-bit words in the array
//   WAIT_CNT   wait cycles inserted per OKAY data phase (0..15)
// Ports
//   i_hclk      clock, all state on rising edge
//   i_hreset_n  synchronous active-low reset
//   i_hsel      slave select from the decoder (address-phase qualifier)
//   i_haddr     address; only the array offset bits are decoded here
//   i_htrans    IDLE/BUSY/NONSEQ/SEQ
//   i_hwrite    1 = write
//   i_hsize     0 = byte, 1 = half, 2 = word
//   i_hburst    burst type, informational only
//   i_hprot     protection, ignored
//   i_hwdata    write data, sampled on the closing edge of a write data phase
//   i_hreadyi   bus HREADY; an address phase is taken only when high
//   o_hrdata    read data, full word in the DATA cycle of a read, else 0
//   o_hreadyo   this slave's HREADY
//   o_hresp     OKAY (2'b00) / ERROR (2'b01)
module ahb2_sram_slv #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned WAIT_CNT  = 0
) (
  input  logic        i_hclk,
  input  logic        i_hreset_n,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [3:0]  i_hprot,
  input  logic [31:0] i_hwdata,
  input  logic        i_hreadyi,
  output logic [31:0] o_hrdata,
  output logic        o_hreadyo,
  output logic [1:0]  o_hresp
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Word index is decoded one bit wider than the array so an access just past the end
  // raises ERROR instead of aliasing onto word 0.
  localparam int unsigned IW = AW + 1;
  localparam logic [IW-1:0] DEPTH_L = IW'(MEM_DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [2:0]    r_state, w_state_d;
  logic [3:0]    r_cnt, w_cnt_d;
  logic [AW-1:0] r_idx, w_idx_d;
  logic [1:0]    r_lane, w_lane_d;
  logic [1:0]    r_size, w_size_d;
  logic          r_write, w_write_d;
  logic          r_hreadyo;
  logic [1:0]    r_hresp;
  logic [31:0]   r_hrdata, w_hrdata_d;
  logic [31:0]   r_mem [MEM_DEPTH];

  logic          w_accept;
  logic          w_err;
  logic [IW-1:0] w_idx_full;
  logic          w_commit;
  logic [3:0]    w_be;
  logic          w_rd_load;
  logic          w_unused;

  assign w_unused   = ^{i_hburst, i_hprot, i_htrans[0], i_haddr[31:AW+3]};

  assign w_accept   = i_hsel & i_hreadyi & i_htrans[1];
  assign w_idx_full = i_haddr[IW+1:2];
  assign w_err      = (i_hsize > 3'd2) ||
                      ((i_hsize == 3'd1) && i_haddr[0]) ||
                      ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00)) ||
                      (w_idx_full >= DEPTH_L);

  // Next state and captured address-phase attributes.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_lane_d  = r_lane;
    w_size_d  = r_size;
    w_write_d = r_write;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_d = ST_DATA;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all drive HREADY high, so each may take a new address phase.
        w_state_d = ST_IDLE;
        if (w_accept) begin
          w_idx_d   = w_idx_full[AW-1:0];
          w_lane_d  = i_haddr[1:0];
          w_size_d  = i_hsize[1:0];
          w_write_d = i_hwrite;
          if (w_err) begin
            w_state_d = ST_ERR1;
          end else if (WAIT_CNT > 0) begin
            w_state_d = ST_WAIT;
            w_cnt_d   = 4'(WAIT_CNT - 1);
          end else begin
            w_state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  assign w_commit = (r_state == ST_DATA) && r_write;

  // Little-endian byte lanes selected by size and low address bits.
  always_comb begin
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = 4'b0011 << r_lane;
      default: w_be = 4'b1111;
    endcase
  end

  // Read data is registered on entry to DATA; bytes being written on that same edge are
  // forwarded so a pipelined read-after-write never sees stale data.
  assign w_rd_load = (w_state_d == ST_DATA) && !w_write_d;

  always_comb begin
    w_hrdata_d = 32'h0;
    if (w_rd_load) begin
      w_hrdata_d = r_mem[w_idx_d];
      if (w_commit && (r_idx == w_idx_d)) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) begin
            w_hrdata_d[8*b +: 8] = i_hwdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_lane    <= 2'd0;
      r_size    <= 2'd0;
      r_write   <= 1'b0;
      r_hreadyo <= 1'b1;
      r_hresp   <= RESP_OKAY;
      r_hrdata  <= 32'h0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_idx     <= w_idx_d;
      r_lane    <= w_lane_d;
      r_size    <= w_size_d;
      r_write   <= w_write_d;
      r_hreadyo <= !((w_state_d == ST_WAIT) || (w_state_d == ST_ERR1));
      r_hresp   <= ((w_state_d == ST_ERR1) || (w_state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
      r_hrdata  <= w_hrdata_d;
    end
  end

  // SRAM array: not cleared by reset; a write due on a reset edge is dropped.
  always_ff @(posedge i_hclk) begin
    if (i_hreset_n && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
        end
      end
    end
  end

  assign o_hrdata  = r_hrdata;
  assign o_hreadyo = r_hreadyo;
  assign o_hresp   = r_hresp;

endmodule
